// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: controller state,
// opcode/funct values and the datapath select codes. The AluOp values are
// also decoded by the ALU control unit, so both sides import them from here.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ORIEX   = 4'd10,
    S_ORIWB   = 4'd11,
    S_JUMP    = 4'd12,
    S_JR      = 4'd13,
    S_JAL     = 4'd14,
    S_ILLEGAL = 4'd15
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // Funct codes (IR[5:0]) that change the control sequence
  localparam logic [5:0] FN_SLL = 6'd0;
  localparam logic [5:0] FN_JR  = 6'd8;

  // AluOp encodings
  localparam logic [2:0] ALUOP_ADD   = 3'd0;
  localparam logic [2:0] ALUOP_SUB   = 3'd1;
  localparam logic [2:0] ALUOP_FUNCT = 3'd2;
  localparam logic [2:0] ALUOP_OR    = 3'd3;
  localparam logic [2:0] ALUOP_SLL   = 3'd4;

  // ALUSrcB selects
  localparam logic [2:0] SRCB_B       = 3'd0;
  localparam logic [2:0] SRCB_FOUR    = 3'd1;
  localparam logic [2:0] SRCB_SEXT    = 3'd2;
  localparam logic [2:0] SRCB_SEXT_SH = 3'd3;
  localparam logic [2:0] SRCB_ZEXT    = 3'd4;

  // RegDst selects
  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  // MemtoReg selects
  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  // PCSource selects
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REGA   = 2'd3;

endpackage

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath. Moore outputs per state,
// except IRWrite/PCWrite in FETCH which wait for mem_ready.
// Optional feature: define MULTICYCLE_JAL_EN to add the JAL state (opcode 3);
// without it opcode 3 is treated as an illegal instruction.
module multicycle_main_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] PCSource,
  output logic [2:0] AluOp,
  output logic       illegal_op
);

  state_t state_q, state_d;

  // State register with synchronous reset; reset aborts any instruction in flight.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  // Next-state decode; opcode/func are only consulted in DECODE and MEMADR.
  // NOTE: state_d gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = (func == FN_JR) ? S_JR : S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ORI:       state_d = S_ORIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_JAL_EN
          OP_JAL:       state_d = S_JAL;
`endif
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ORIEX:  state_d = S_ORIWB;
      default:  state_d = S_FETCH;   // MEMWB, ALUWB, ORIWB, BRANCH, JUMP, JR, JAL, ILLEGAL
    endcase
  end

  // Output decode: everything 0 unless the current state drives it.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    RegDst      = REGDST_RT;
    MemtoReg    = M2R_ALUOUT;
    PCSource    = PCSRC_ALU;
    AluOp       = ALUOP_ADD;
    illegal_op  = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = SRCB_SEXT_SH;   // branch target into ALUOut
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_SEXT;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = M2R_MDR;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        AluOp   = (func == FN_SLL) ? ALUOP_SLL : ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = REGDST_RD;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        AluOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_ORIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_ZEXT;
        AluOp   = ALUOP_OR;
      end
      S_ORIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_REGA;
      end
`ifdef MULTICYCLE_JAL_EN
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
        RegWrite = 1'b1;
        RegDst   = REGDST_RA;
        MemtoReg = M2R_PC;          // PC already holds PC+4
      end
`endif
      S_ILLEGAL: illegal_op = 1'b1;
      default: ;                      // RESET: all outputs stay 0
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Table-driven bench for multicycle_main_control. Each row gives the inputs
// for one cycle and the outputs expected during that cycle (before the edge).
module tb_multicycle_main_control;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rw;
    logic       srca;
    logic [2:0] srcb;
    logic [1:0] rdst;
    logic [1:0] m2r;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic       ill;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       rdy;
    outs_t      exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, func;
  logic       mem_ready;
  outs_t      act;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  multicycle_main_control dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .func        (func),
    .mem_ready   (mem_ready),
    .PCWrite     (act.pcw),
    .PCWriteCond (act.pcwc),
    .IorD        (act.iord),
    .MemRead     (act.mrd),
    .MemWrite    (act.mwr),
    .IRWrite     (act.irw),
    .RegWrite    (act.rw),
    .ALUSrcA     (act.srca),
    .ALUSrcB     (act.srcb),
    .RegDst      (act.rdst),
    .MemtoReg    (act.m2r),
    .PCSource    (act.pcsrc),
    .AluOp       (act.aluop),
    .illegal_op  (act.ill)
  );

  // Expected output sets per state, written out from the state descriptions.
  function automatic outs_t o_zero();   outs_t o = '0; return o; endfunction
  function automatic outs_t o_fetch(input logic r);
    outs_t o = '0; o.mrd = 1; o.srcb = 3'd1; o.irw = r; o.pcw = r; return o;
  endfunction
  function automatic outs_t o_decode(); outs_t o = '0; o.srcb = 3'd3; return o; endfunction
  function automatic outs_t o_memadr(); outs_t o = '0; o.srca = 1; o.srcb = 3'd2; return o; endfunction
  function automatic outs_t o_memrd();  outs_t o = '0; o.mrd = 1; o.iord = 1; return o; endfunction
  function automatic outs_t o_memwb();  outs_t o = '0; o.rw = 1; o.m2r = 2'd1; return o; endfunction
  function automatic outs_t o_memwr();  outs_t o = '0; o.mwr = 1; o.iord = 1; return o; endfunction
  function automatic outs_t o_exec(input logic [2:0] a);
    outs_t o = '0; o.srca = 1; o.aluop = a; return o;
  endfunction
  function automatic outs_t o_aluwb();  outs_t o = '0; o.rw = 1; o.rdst = 2'd1; return o; endfunction
  function automatic outs_t o_branch();
    outs_t o = '0; o.srca = 1; o.aluop = 3'd1; o.pcwc = 1; o.pcsrc = 2'd1; return o;
  endfunction
  function automatic outs_t o_oriex();
    outs_t o = '0; o.srca = 1; o.srcb = 3'd4; o.aluop = 3'd3; return o;
  endfunction
  function automatic outs_t o_oriwb();  outs_t o = '0; o.rw = 1; return o; endfunction
  function automatic outs_t o_jump();   outs_t o = '0; o.pcw = 1; o.pcsrc = 2'd2; return o; endfunction
  function automatic outs_t o_jr();     outs_t o = '0; o.pcw = 1; o.pcsrc = 2'd3; return o; endfunction
  function automatic outs_t o_jal();
    outs_t o = '0; o.pcw = 1; o.pcsrc = 2'd2; o.rw = 1; o.rdst = 2'd2; o.m2r = 2'd2; return o;
  endfunction
  function automatic outs_t o_illegal(); outs_t o = '0; o.ill = 1; return o; endfunction

  task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic rdy, input outs_t e);
    vec_t v;
    v.rst = r; v.op = op; v.fn = fn; v.rdy = rdy; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input int idx, input outs_t got, input outs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL vec%0d outputs: got %h expected %h", idx, got, exp);
    end
  endtask

  initial begin
    // Reset release: one RESET cycle, then FETCH with a ready memory.
    add(0, 6'd35, 6'd0, 1, o_zero());
    // lw, zero wait: 5 cycles
    add(0, 6'd35, 6'd0, 1, o_fetch(1));
    add(0, 6'd35, 6'd0, 0, o_decode());   // mem_ready ignored here
    add(0, 6'd35, 6'd0, 0, o_memadr());
    add(0, 6'd35, 6'd0, 1, o_memrd());
    add(0, 6'd35, 6'd0, 0, o_memwb());
    // sw: 4 cycles
    add(0, 6'd43, 6'd0, 1, o_fetch(1));
    add(0, 6'd43, 6'd0, 1, o_decode());
    add(0, 6'd43, 6'd0, 1, o_memadr());
    add(0, 6'd43, 6'd0, 1, o_memwr());
    // R-type add (func 32)
    add(0, 6'd0, 6'd32, 1, o_fetch(1));
    add(0, 6'd0, 6'd32, 1, o_decode());
    add(0, 6'd0, 6'd32, 1, o_exec(3'd2));
    add(0, 6'd0, 6'd32, 1, o_aluwb());
    // all-zero instruction: sll
    add(0, 6'd0, 6'd0, 1, o_fetch(1));
    add(0, 6'd0, 6'd0, 1, o_decode());
    add(0, 6'd0, 6'd0, 1, o_exec(3'd4));
    add(0, 6'd0, 6'd0, 1, o_aluwb());
    // jr
    add(0, 6'd0, 6'd8, 1, o_fetch(1));
    add(0, 6'd0, 6'd8, 1, o_decode());
    add(0, 6'd0, 6'd8, 1, o_jr());
    // ori
    add(0, 6'd13, 6'd5, 1, o_fetch(1));
    add(0, 6'd13, 6'd5, 1, o_decode());
    add(0, 6'd13, 6'd5, 1, o_oriex());
    add(0, 6'd13, 6'd5, 1, o_oriwb());
    // beq after a 3-cycle fetch stall
    add(0, 6'd4, 6'd0, 0, o_fetch(0));
    add(0, 6'd4, 6'd0, 0, o_fetch(0));
    add(0, 6'd4, 6'd0, 0, o_fetch(0));
    add(0, 6'd4, 6'd0, 1, o_fetch(1));
    add(0, 6'd4, 6'd0, 1, o_decode());
    add(0, 6'd4, 6'd0, 1, o_branch());
    // j
    add(0, 6'd2, 6'd0, 1, o_fetch(1));
    add(0, 6'd2, 6'd0, 1, o_decode());
    add(0, 6'd2, 6'd0, 1, o_jump());
    // opcode 3
    add(0, 6'd3, 6'd0, 1, o_fetch(1));
    add(0, 6'd3, 6'd0, 1, o_decode());
`ifdef MULTICYCLE_JAL_EN
    add(0, 6'd3, 6'd0, 1, o_jal());
`else
    add(0, 6'd3, 6'd0, 1, o_illegal());
`endif
    // unsupported opcode 63: single illegal pulse, then FETCH
    add(0, 6'd63, 6'd0, 1, o_fetch(1));
    add(0, 6'd63, 6'd0, 1, o_decode());
    add(0, 6'd63, 6'd0, 1, o_illegal());
    // lw with two MEMRD wait cycles
    add(0, 6'd35, 6'd0, 1, o_fetch(1));
    add(0, 6'd35, 6'd0, 1, o_decode());
    add(0, 6'd35, 6'd0, 1, o_memadr());
    add(0, 6'd35, 6'd0, 0, o_memrd());
    add(0, 6'd35, 6'd0, 0, o_memrd());
    add(0, 6'd35, 6'd0, 1, o_memrd());
    add(0, 6'd35, 6'd0, 1, o_memwb());
    // sw with one MEMWR wait cycle
    add(0, 6'd43, 6'd0, 1, o_fetch(1));
    add(0, 6'd43, 6'd0, 1, o_decode());
    add(0, 6'd43, 6'd0, 1, o_memadr());
    add(0, 6'd43, 6'd0, 0, o_memwr());
    add(0, 6'd43, 6'd0, 1, o_memwr());
    // reset asserted while stalled in MEMRD aborts the lw
    add(0, 6'd35, 6'd0, 1, o_fetch(1));
    add(0, 6'd35, 6'd0, 1, o_decode());
    add(0, 6'd35, 6'd0, 1, o_memadr());
    add(1, 6'd35, 6'd0, 0, o_memrd());
    add(0, 6'd35, 6'd0, 1, o_zero());
    add(0, 6'd35, 6'd0, 1, o_fetch(1));
    add(0, 6'd35, 6'd0, 1, o_decode());

    // Reset held for two edges.
    reset = 1'b1; opcode = '0; func = '0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check(-1, act, o_zero());   // RESET state while reset still high

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset     = vecs[i].rst;
      opcode    = vecs[i].op;
      func      = vecs[i].fn;
      mem_ready = vecs[i].rdy;
      #1 check(i, act, vecs[i].exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
